// File: rtl/inst_rom_loader.sv
// Instruction ROM with a byte-stream image loader.
//
// Holds a DEPTH x 32 instruction array (DEPTH = 2^ADDR_W). The CPU fetches
// combinationally through ce_i/addr_i/inst_o while the block is idle. A load
// is started by load_start_i and then fills the array from a valid/ready
// byte stream, big-endian within each word. The pipeline is stalled for the
// whole load and for the one-cycle DONE state.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   ce_i, addr_i, inst_o   fetch enable, byte address, fetched word (0 = NOP)
//   stallreq_o             pipeline pause request while loading
//   load_start_i           one-cycle pulse that starts a load
//   load_len_i             words to load, clamped to DEPTH, sampled on start
//   ld_valid_i, ld_data_i  loader byte stream
//   ld_ready_o             byte ready, high only while loading
//   load_done_o            one-cycle pulse after the last word is written
//   checksum_o             modulo-256 sum of bytes accepted in this/last load
module inst_rom_loader #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [31:0]       addr_i,
  output logic [31:0]       inst_o,
  output logic              stallreq_o,
  input  logic              load_start_i,
  input  logic [ADDR_W:0]   load_len_i,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_data_i,
  output logic              ld_ready_o,
  output logic              load_done_o,
  output logic [7:0]        checksum_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DepthLen = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [23:0]         word_q, word_d;   // first three bytes of the word in flight
  logic [7:0]          csum_q, csum_d;

  logic                mem_we;
  logic [31:0]         mem_wdata;
  logic [31:0]         mem [Depth];

  // Byte lane bits carry no word-address information.
  logic                unused_addr_lsb;
  assign unused_addr_lsb = ^addr_i[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
    end
  end

  // Storage is deliberately outside the reset domain so a reset keeps the image.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr_q] <= mem_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ptr_d     = ptr_q;
    bcnt_d    = bcnt_q;
    word_d    = word_q;
    csum_d    = csum_q;
    mem_we    = 1'b0;
    mem_wdata = {word_q, ld_data_i};

    unique case (state_q)
      StIdle: begin
        if (load_start_i) begin
          len_d   = (load_len_i > DepthLen) ? DepthLen : load_len_i;
          ptr_d   = '0;
          bcnt_d  = '0;
          word_d  = '0;
          csum_d  = '0;
          state_d = (load_len_i == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (ld_valid_i) begin
          csum_d = csum_q + ld_data_i;
          bcnt_d = bcnt_q + 2'd1;
          word_d = {word_q[15:0], ld_data_i};
          if (bcnt_q == 2'd3) begin
            mem_we = 1'b1;
            // Pointer stays on the last index so it never wraps past DEPTH-1.
            if ({1'b0, ptr_q} == len_q - 1'b1) begin
              state_d = StDone;
            end else begin
              ptr_d = ptr_q + 1'b1;
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign ld_ready_o  = (state_q == StLoad);
  assign load_done_o = (state_q == StDone);
  assign stallreq_o  = (state_q != StIdle);
  assign checksum_o  = csum_q;

  // rst is included so the output is a clean NOP even while the array holds X.
  always_comb begin
    inst_o = 32'h0;
    if (rst && ce_i && (state_q == StIdle) && (addr_i[31:ADDR_W+2] == '0)) begin
      inst_o = mem[addr_i[ADDR_W+1:2]];
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
module tb_inst_rom_loader;

  localparam int unsigned AddrW = 10;
  localparam int unsigned Depth = 1 << AddrW;

  logic             clk;
  logic             rst;
  logic             ce_i;
  logic [31:0]      addr_i;
  logic [31:0]      inst_o;
  logic             stallreq_o;
  logic             load_start_i;
  logic [AddrW:0]   load_len_i;
  logic             ld_valid_i;
  logic [7:0]       ld_data_i;
  logic             ld_ready_o;
  logic             load_done_o;
  logic [7:0]       checksum_o;

  inst_rom_loader #(.ADDR_W(AddrW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .addr_i       (addr_i),
    .inst_o       (inst_o),
    .stallreq_o   (stallreq_o),
    .load_start_i (load_start_i),
    .load_len_i   (load_len_i),
    .ld_valid_i   (ld_valid_i),
    .ld_data_i    (ld_data_i),
    .ld_ready_o   (ld_ready_o),
    .load_done_o  (load_done_o),
    .checksum_o   (checksum_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   num_cmp = 0;
  int   num_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_cmp++;
    if (obs !== exp) begin
      num_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gen_byte(input int sel, input int i);
    logic [7:0] tbl [8];
    int k;
    tbl = '{8'h24, 8'h02, 8'h00, 8'h05, 8'h34, 8'h03, 8'h00, 8'h07};
    k = i / 4;
    case (sel)
      0: return tbl[i % 8];
      1: begin
        case (i % 4)
          0: return 8'((k >> 8) & 3);
          1: return 8'(k & 255);
          2: return 8'h5a;
          default: return 8'((~k) & 255);
        endcase
      end
      default: return 8'(8'ha0 + i);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a complete load and pushes every expected word to the scoreboard.
  task automatic run_load(input int len_req, input int sel, input int gap);
    int          clamp;
    logic [7:0]  b;
    logic [7:0]  csum;
    logic [31:0] w;
    int          bad;
    int          early;
    clamp = (len_req > Depth) ? Depth : len_req;
    csum  = 8'h0;
    w     = 32'h0;
    bad   = 0;
    early = 0;
    load_start_i = 1'b1;
    load_len_i   = (AddrW+1)'(len_req);
    tick();
    load_start_i = 1'b0;
    load_len_i   = '0;
    for (int i = 0; i < 4 * clamp; i++) begin
      for (int g = 0; g < gap; g++) begin
        ld_valid_i = 1'b0;
        if (!stallreq_o || !ld_ready_o || load_done_o) bad++;
        tick();
      end
      b = gen_byte(sel, i);
      ld_valid_i = 1'b1;
      ld_data_i  = b;
      if (!stallreq_o || !ld_ready_o || load_done_o) bad++;
      tick();
      ld_valid_i = 1'b0;
      csum = csum + b;
      w = {w[23:0], b};
      if (i % 4 == 3) exp_q.push_back('{addr: i / 4, data: w});
      if (i != 4 * clamp - 1 && load_done_o) early++;
    end
    check_eq("load_handshake", 32'(bad), 32'd0);
    check_eq("no_early_done", 32'(early), 32'd0);
    check_eq("done_pulse", {31'b0, load_done_o}, 32'd1);
    check_eq("done_stall", {31'b0, stallreq_o}, 32'd1);
    check_eq("done_ready", {31'b0, ld_ready_o}, 32'd0);
    check_eq("checksum", {24'b0, checksum_o}, {24'b0, csum});
    tick();
    check_eq("done_fall", {31'b0, load_done_o}, 32'd0);
    check_eq("stall_fall", {31'b0, stallreq_o}, 32'd0);
    repeat (3) tick();
    check_eq("checksum_hold", {24'b0, checksum_o}, {24'b0, csum});
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      ce_i   = 1'b1;
      addr_i = (32'(e.addr) << 2) | 32'($urandom_range(0, 3));
      #1;
      check_eq($sformatf("mem[%0d]", e.addr), inst_o, e.data);
    end
    ce_i = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    ce_i         = 1'b1;
    addr_i       = 32'h0;
    load_start_i = 1'b0;
    load_len_i   = '0;
    ld_valid_i   = 1'b0;
    ld_data_i    = 8'h0;
    #12;
    check_eq("rst_stall", {31'b0, stallreq_o}, 32'd0);
    check_eq("rst_ready", {31'b0, ld_ready_o}, 32'd0);
    check_eq("rst_done", {31'b0, load_done_o}, 32'd0);
    check_eq("rst_csum", {24'b0, checksum_o}, 32'd0);
    check_eq("rst_inst", inst_o, 32'h0);
    ce_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Full-rate two-word load.
    run_load(2, 0, 0);
    check_eq("sb_words_full", 32'(exp_q.size()), 32'd2);
    drain();

    // Valid outside LOAD must be ignored.
    ld_valid_i = 1'b1;
    ld_data_i  = 8'hff;
    repeat (2) tick();
    check_eq("idle_ready", {31'b0, ld_ready_o}, 32'd0);
    check_eq("idle_valid_ignored", {24'b0, checksum_o}, 32'h69);
    ld_valid_i = 1'b0;

    // Same image with three idle cycles before each byte.
    run_load(2, 0, 3);
    drain();

    // Fetch decode.
    ce_i = 1'b1; addr_i = 32'h4; #1;
    check_eq("fetch_4", inst_o, 32'h34030007);
    addr_i = 32'h1000; #1;
    check_eq("fetch_out_of_range", inst_o, 32'h0);
    addr_i = 32'hffff_fff4; #1;
    check_eq("fetch_high_bits", inst_o, 32'h0);
    addr_i = 32'h4; ce_i = 1'b0; #1;
    check_eq("fetch_ce_low", inst_o, 32'h0);

    // Zero-length load goes straight to DONE without writing.
    run_load(0, 0, 0);
    exp_q.push_back('{addr: 0, data: 32'h24020005});
    exp_q.push_back('{addr: 1, data: 32'h34030007});
    drain();

    // Reset after six bytes of a four-word load.
    tick();
    load_start_i = 1'b1;
    load_len_i   = 11'd4;
    tick();
    load_start_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ld_valid_i = 1'b1;
      ld_data_i  = gen_byte(2, i);
      tick();
    end
    ld_valid_i = 1'b0;
    ce_i = 1'b1;
    addr_i = 32'h0;
    rst = 1'b0;
    #1;
    check_eq("abort_stall", {31'b0, stallreq_o}, 32'd0);
    check_eq("abort_ready", {31'b0, ld_ready_o}, 32'd0);
    check_eq("abort_done", {31'b0, load_done_o}, 32'd0);
    check_eq("abort_csum", {24'b0, checksum_o}, 32'd0);
    check_eq("abort_inst", inst_o, 32'h0);
    ce_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    exp_q.push_back('{addr: 0, data: 32'ha0a1a2a3});
    exp_q.push_back('{addr: 1, data: 32'h34030007});
    drain();
    run_load(2, 0, 0);
    drain();

    // Oversized length clamps to the whole array.
    run_load(Depth + 5, 1, 0);
    check_eq("sb_words_clamp", 32'(exp_q.size()), 32'(Depth));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
INST_ROM_LOADER -- requirements
Module: inst_rom_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving the word-address width (DEPTH = 2^ADDR_W words of 32 bits).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low; clears state immediately when low.
REQ-004 SHALL have port ce_i  input  1  fetch enable from the CPU program counter.
REQ-005 SHALL have port addr_i  input  32  byte fetch address from the CPU.
REQ-006 SHALL have port inst_o  output  32  fetched instruction word to the CPU.
REQ-007 SHALL have port stallreq_o  output  1  pipeline pause request to the control block.
REQ-008 SHALL have port load_start_i  input  1  single-cycle pulse that starts an image load.
REQ-009 SHALL have port load_len_i  input  ADDR_W+1  number of words to load; sampled on load_start_i.
REQ-010 SHALL have port ld_valid_i  input  1  loader byte valid.
REQ-011 SHALL have port ld_data_i  input  8  loader byte.
REQ-012 SHALL have port ld_ready_o  output  1  loader byte ready.
REQ-013 SHALL have port load_done_o  output  1  single-cycle pulse at the end of a load.
REQ-014 SHALL have port checksum_o  output  8  modulo-256 sum of the bytes accepted in the current or last load.

Function
REQ-015 SHALL hold a DEPTH x 32 storage array that is not cleared by reset.
REQ-016 SHALL implement states IDLE, LOAD and DONE; reset state is IDLE.
REQ-017 IDLE: on load_start_i=1, SHALL latch min(load_len_i, DEPTH) as the length, clear the word pointer, byte counter and checksum, and go to LOAD; if the latched length is 0, SHALL go directly to DONE.
REQ-018 LOAD: ld_ready_o SHALL be 1; in every other state it SHALL be 0.
REQ-019 A byte SHALL be accepted on a cycle with ld_valid_i=1 and ld_ready_o=1, and only on such a cycle; ld_valid_i is ignored otherwise.
REQ-020 Each accepted byte SHALL be added to checksum_o, modulo 256, on the same edge.
REQ-021 Accepted bytes SHALL be assembled big-endian: byte 0 goes to bits [31:24] and byte 3 to bits [7:0].
REQ-022 On acceptance of the 4th byte, the assembled word SHALL be written to array[word pointer] on that edge, and the word pointer SHALL increment.
REQ-023 When the written word is the last one (pointer = length-1), the state SHALL go to DONE on the same edge.
REQ-024 DONE SHALL last exactly one cycle with load_done_o=1, then return to IDLE.
REQ-025 load_start_i SHALL be ignored in LOAD and in DONE.
REQ-026 stallreq_o SHALL be 1 in LOAD and in DONE, and 0 in IDLE.
REQ-027 inst_o SHALL be combinational, equal to array[addr_i[ADDR_W+1:2]] when all of the following hold: ce_i=1, state=IDLE, and addr_i[31:ADDR_W+2]=0.
REQ-028 When any condition in REQ-027 fails, inst_o SHALL be 32'h0 (NOP).
REQ-029 addr_i[1:0] SHALL be ignored.
REQ-030 The word pointer SHALL never exceed DEPTH-1; a length clamped to DEPTH fills the whole array, with no wrap-around.
REQ-031 checksum_o SHALL hold its value after DONE until the next accepted load_start_i.

Reset
REQ-032 While rst=0, the block SHALL force state IDLE, pointers and byte counter to 0, checksum_o=0, ld_ready_o=0, load_done_o=0, stallreq_o=0 and inst_o=0.
REQ-033 A reset asserted mid-load SHALL abort the load and discard the partial word; array words already written SHALL keep their contents.

Verification
REQ-034 Reset, then load_start_i with len=2 and bytes 24,02,00,05,34,03,00,07 at full rate -> array[0]=32'h24020005, array[1]=32'h34030007, load_done_o pulses 1 cycle after the 8th byte edge, checksum_o=8'h69.
REQ-035 Same load with ld_valid_i low for 3 cycles between each byte -> identical array contents and checksum; stallreq_o stays 1 until load_done_o falls.
REQ-036 After the load: ce_i=1, addr_i=32'h4 -> inst_o=32'h34030007; addr_i=32'h1000 (ADDR_W=10) -> 0; ce_i=0 -> 0.
REQ-037 load_start_i with len=0 -> DONE on the next edge, load_done_o pulses 1 cycle, checksum_o=0, no array write.
REQ-038 Start a len=4 load, drive rst low after 6 bytes -> array[0] written, array[1] unchanged, outputs at reset values, next load_start_i accepted normally.
REQ-039 load_len_i=2^ADDR_W+5 -> exactly DEPTH words written, load_done_o after 4*DEPTH bytes, no write to index 0 after the first word.
